// File: rtl/keccak_out_sched.sv
// Output scheduler for Keccak permutation cores.
// Round-robin capture, one-deep pending buffer, 8-beat streaming.
module keccak_out_sched #(
  parameter int NCORES = 2,
  parameter int TAGW   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCORES-1:0]        req,
  input  logic [NCORES*1600-1:0]   din,
  input  logic [NCORES*TAGW-1:0]   tagin,
  output logic [NCORES-1:0]        gnt,
  output logic [199:0]             dout,
  output logic [2:0]               doutix,
  output logic [TAGW-1:0]          tagout,
  output logic                     pushout,
  output logic                     busy
);

  localparam int RRW = $clog2(NCORES);
  localparam logic [RRW-1:0] LAST = RRW'(NCORES - 1);

  logic [1599:0]   act_st;
  logic [1599:0]   pend_st;
  logic [TAGW-1:0] act_tag;
  logic [TAGW-1:0] pend_tag;
  logic            act_v;
  logic            pend_v;
  logic [2:0]      ix;
  logic [RRW-1:0]  rr;

  logic            last_beat;
  logic            accept;
  logic            hit;
  logic            take;
  logic            to_act;
  logic            swap;
  logic [RRW-1:0]  gidx;
  logic [RRW-1:0]  cand;
  logic [RRW-1:0]  rr_next;
  logic [1599:0]   new_st;
  logic [TAGW-1:0] new_tag;
  logic [199:0]    beat;

  assign last_beat = act_v && (ix == 3'd7);
  assign accept    = !pend_v || last_beat;
  assign take      = reset && accept && hit;
  assign to_act    = !act_v || (last_beat && !pend_v);
  assign swap      = last_beat && pend_v;
  assign busy      = act_v || pend_v;
  assign rr_next   = (gidx == LAST) ? '0 : gidx + RRW'(1);

  // First requester at or above rr, wrapping.
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    cand = rr;
    for (int k = 0; k < NCORES; k++) begin
      if (!hit && req[cand]) begin
        hit  = 1'b1;
        gidx = cand;
      end
      cand = (cand == LAST) ? '0 : cand + RRW'(1);
    end
  end

  // One-hot grant, suppressed while reset is held.
  always_comb begin
    gnt = '0;
    if (take) gnt[gidx] = 1'b1;
  end

  // Select granted core's state and tag.
  always_comb begin
    new_st  = '0;
    new_tag = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (gidx == RRW'(i)) begin
        new_st  = din[1600*i +: 1600];
        new_tag = tagin[TAGW*i +: TAGW];
      end
    end
  end

  // Current beat slice of the active state.
  always_comb begin
    beat = act_st[199:0];
    for (int b = 0; b < 8; b++) begin
      if (ix == 3'(b)) beat = act_st[200*b +: 200];
    end
  end

  // Slot routing, beat counter and registered output stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_st   <= '0;
      pend_st  <= '0;
      act_tag  <= '0;
      pend_tag <= '0;
      act_v    <= 1'b0;
      pend_v   <= 1'b0;
      ix       <= '0;
      rr       <= '0;
      dout     <= '0;
      doutix   <= '0;
      tagout   <= '0;
      pushout  <= 1'b0;
    end else begin
      if (act_v) begin
        pushout <= 1'b1;
        doutix  <= ix;
        dout    <= beat;
        tagout  <= act_tag;
        ix      <= ix + 3'd1;
      end else begin
        pushout <= 1'b0;
        doutix  <= '0;
      end
      if (take) begin
        rr <= rr_next;
        unique case (1'b1)
          to_act: begin
            act_st  <= new_st;
            act_tag <= new_tag;
            act_v   <= 1'b1;
            ix      <= '0;
          end
          swap: begin
            act_st   <= pend_st;
            act_tag  <= pend_tag;
            pend_st  <= new_st;
            pend_tag <= new_tag;
            ix       <= '0;
          end
          default: begin
            pend_st  <= new_st;
            pend_tag <= new_tag;
            pend_v   <= 1'b1;
          end
        endcase
      end else if (last_beat) begin
        ix <= '0;
        if (pend_v) begin
          act_st  <= pend_st;
          act_tag <= pend_tag;
          pend_v  <= 1'b0;
        end else begin
          act_v <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keccak_out_sched.sv
// Scoreboard bench for keccak_out_sched.
// Queue-of-results reference model, decoupled output monitor.
module tb_keccak_out_sched;

  localparam int N  = 4;
  localparam int TW = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*1600-1:0] din = '0;
  logic [N*TW-1:0]   tagin = '0;
  logic [N-1:0]      gnt;
  logic [199:0]      dout;
  logic [2:0]        doutix;
  logic [TW-1:0]     tagout;
  logic              pushout;
  logic              busy;

  keccak_out_sched #(.NCORES(N), .TAGW(TW)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din),
    .tagin(tagin), .gnt(gnt), .dout(dout),
    .doutix(doutix), .tagout(tagout),
    .pushout(pushout), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [199:0] act,
                     input logic [199:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1599:0] st;
    logic [TW-1:0] tag;
  } res_t;

  typedef struct {
    logic          push;
    logic          bsy;
    logic [199:0]  d;
    logic [2:0]    ix;
    logic [TW-1:0] tag;
  } exp_t;

  res_t         m_items[$];
  exp_t         sb[$];
  int           m_b = 0;
  int           m_rr = 0;
  logic [199:0] m_last = '0;

  // Reference model: outstanding results form a queue of at most two.
  always @(posedge clk) begin
    logic [N-1:0] eg;
    int gi;
    exp_t e;
    res_t r;
    eg = '0;
    gi = -1;
    e = '{push: 1'b0, bsy: 1'b0, d: '0, ix: '0, tag: '0};
    if (!reset) begin
      chk("gnt_in_reset", 200'(gnt), 200'(0));
      m_items.delete();
      m_b = 0;
      m_rr = 0;
      m_last = '0;
      e.d = '0;
    end else begin
      if (m_items.size() < 2 || m_b == 7) begin
        for (int k = 0; k < N; k++)
          if (gi < 0 && req[(m_rr + k) % N]) gi = (m_rr + k) % N;
      end
      if (gi >= 0) eg[gi] = 1'b1;
      chk("gnt", 200'(gnt), 200'(eg));
      if (m_items.size() > 0) begin
        e.push = 1'b1;
        e.d    = m_items[0].st[200*m_b +: 200];
        e.ix   = 3'(m_b);
        e.tag  = m_items[0].tag;
        m_last = e.d;
        m_b++;
        if (m_b == 8) begin
          void'(m_items.pop_front());
          m_b = 0;
        end
      end else begin
        e.d = m_last;
      end
      if (gi >= 0) begin
        r.st  = din[1600*gi +: 1600];
        r.tag = tagin[TW*gi +: TW];
        m_items.push_back(r);
        m_rr = (gi + 1) % N;
      end
      e.bsy = (m_items.size() > 0);
    end
    sb.push_back(e);
  end

  // Output monitor: one expected entry per clock.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pushout", 200'(pushout), 200'(e.push));
      chk("busy", 200'(busy), 200'(e.bsy));
      chk("doutix", 200'(doutix), 200'(e.ix));
      chk("dout", dout, e.d);
      if (e.push) chk("tagout", 200'(tagout), 200'(e.tag));
    end
  end

  logic [N-1:0] gsamp = '0;
  always @(posedge clk) gsamp <= gnt;

  int left[N];
  bit rnd = 1'b0;

  function automatic logic [1599:0] rnd1600();
    logic [1599:0] v;
    for (int w = 0; w < 50; w++) v[32*w +: 32] = $urandom();
    return v;
  endfunction

  task automatic step();
    bit dropped;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      dropped = 1'b0;
      if (req[i] && gsamp[i]) begin
        left[i]--;
        req[i] = 1'b0;
      end else if (req[i] && rnd && $urandom_range(15) == 0) begin
        req[i] = 1'b0;
        dropped = 1'b1;
      end
      if (!dropped && !req[i] && left[i] > 0 &&
          (!rnd || $urandom_range(3) == 0)) begin
        din[1600*i +: 1600] = rnd1600();
        tagin[TW*i +: TW] = TW'($urandom());
        req[i] = 1'b1;
      end
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (left[i] != 0) return 1'b0;
    return (req == '0) && !busy && !pushout;
  endfunction

  task automatic drain(input string nm, input int maxc);
    int c;
    c = 0;
    while (c < maxc && !all_done()) begin
      step();
      c++;
    end
    if (c >= maxc) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout after %0d cycles", nm, c);
    end
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < N; i++) left[i] = 0;
    #1;
    chk("rst_pushout", 200'(pushout), 200'(0));
    chk("rst_doutix", 200'(doutix), 200'(0));
    chk("rst_dout", dout, 200'(0));
    chk("rst_tagout", 200'(tagout), 200'(0));
    chk("rst_busy", 200'(busy), 200'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    left[0] = 1;
    left[1] = 1;
    drain("two_same_cycle", 200);

    @(negedge clk);
    din[1599:0] = rnd1600();
    tagin[TW-1:0] = 8'h5A;
    req[0] = 1'b1;
    left[0] = 1;
    drain("single", 200);

    left[0] = 3;
    drain("b2b_core0", 300);

    left[0] = 3;
    left[1] = 3;
    drain("alternate", 400);

    left[0] = 1;
    c = 0;
    while (c < 40 && !(pushout && doutix == 3'd3)) begin
      step();
      c++;
    end
    chk("reach_beat3", 200'(c < 40), 200'(1));
    #2 reset = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) left[i] = 0;
    #1;
    chk("midrst_pushout", 200'(pushout), 200'(0));
    chk("midrst_doutix", 200'(doutix), 200'(0));
    chk("midrst_busy", 200'(busy), 200'(0));
    chk("midrst_dout", dout, 200'(0));
    repeat (3) step();
    #2 reset = 1'b1;
    repeat (10) step();

    left[1] = 1;
    drain("rr_setup", 200);
    left[1] = 1;
    left[3] = 1;
    drain("rr_wrap", 300);

    rnd = 1'b1;
    for (int i = 0; i < N; i++) left[i] = $urandom_range(2, 6);
    drain("random", 3000);
    rnd = 1'b0;

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keccak_out_sched.md
Name: keccak_out_sched

Overview:
- Output-side scheduler between NCORES Keccak permutation cores and the 200-bit output bus.
- Arbitrates completed 1600-bit states (with 8-bit tags) round-robin and buffers one result while another streams.
- Serializes each result as 8 contiguous beats of 200 bits, indexed 0..7.
- Sustains one result per 8 cycles with no bubbles between results.

Parameters:
NCORES, 2, number of requesting permutation cores (2..8)
TAGW, 8, tag width carried with each result

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  NCORES  per-core result-ready request; held high with data stable until granted
din  input  NCORES*1600  per-core final state; core i occupies bits [1600*i +: 1600]
tagin  input  NCORES*TAGW  per-core tag; core i occupies bits [TAGW*i +: TAGW]
gnt  output  NCORES  one-hot combinational grant; data is captured on the clk edge where gnt[i]=1
dout  output  200  current beat data, registered
doutix  output  3  beat index of dout, registered
tagout  output  TAGW  tag of the streaming result, registered
pushout  output  1  dout/doutix/tagout valid this cycle, registered
busy  output  1  active or pending slot holds a result

Behaviour:
- Storage: ACTIVE slot (state, tag, valid) is streaming; PENDING slot (state, tag, valid) is queued. Beat counter ix is 3 bits. Round-robin pointer rr ranges 0..NCORES-1.
- Reset (reset=0): all outputs and state clear asynchronously.
  - pushout=0, doutix=0, dout=0, tagout=0, busy=0, both slots invalid, ix=0, rr=0.
  - gnt=0 while reset is low.
- Grant window (`accept`): asserted when PENDING is invalid, or when ACTIVE is valid with ix=7.
- Grant selection:
  - If accept is asserted and req is non-zero, grant the first set req bit searching upward from rr, wrapping.
  - At most one gnt bit is high at a time.
  - On the granting edge, rr becomes granted index + 1, modulo NCORES.
- Capture routing on a granting edge:
  - ACTIVE invalid, or (ACTIVE at ix=7 and PENDING invalid): the result goes to ACTIVE and ix resets to 0.
  - ACTIVE at ix=7 and PENDING valid: PENDING moves to ACTIVE, the new result goes to PENDING, ix resets to 0.
  - ACTIVE valid with ix<7: the result goes to PENDING.
- Streaming: while ACTIVE is valid, every clk edge registers:
  - pushout=1, doutix=ix, dout=ACTIVE[200*ix +: 200], tagout=ACTIVE tag;
  - then ix increments.
- End of result (edge at ix=7):
  - If PENDING is valid or a grant occurs, the next result becomes ACTIVE with ix=0. The next cycle shows beat 0 of the new result with no gap.
  - Otherwise ACTIVE becomes invalid and pushout=0 on the following cycle.
- Latency: grant edge T on an idle block gives beat 0 at the output after edge T+1. Beats 0..7 appear on 8 consecutive cycles.
- pushout=0 implies doutix=0 and dout holds its last value. tagout is stable across all 8 beats of a result.
- Beats are never aborted, skipped or repeated except by reset. Once granted, a result always emits all 8 beats in order.
- Reset mid-stream: the partial result is dropped and pushout drops asynchronously. After reset release nothing is emitted until a new req.
- busy = ACTIVE valid OR PENDING valid (combinational from the registered valids).
- req deasserted without a grant is legal. The request is simply not served.

Test Plan:
- Idle, core0 req with din=state A, tag 0x5A -> gnt[0] pulse 1 cycle; pushout=1 for exactly 8 cycles, doutix 0..7, dout=A[199:0]..A[1599:1400], tagout=0x5A; then pushout=0, busy=0.
- Core0 and core1 req in the same cycle, rr=0 -> core0 granted first, core1 granted the next cycle into PENDING; 16 contiguous beats, tags core0 then core1; rr=0 afterwards.
- Core0 delivers 3 results back-to-back -> 2nd granted immediately into PENDING, 3rd granted at ACTIVE ix=7; 24 contiguous pushout cycles, doutix wraps 7->0 with no gap.
- Both cores hold req continuously for 6 results -> grants alternate 0,1,0,1,0,1; never two gnt bits high; no pushout gap.
- reset driven low at beat 3 -> pushout=0 and doutix=0 immediately; after release with no req, pushout stays 0 and busy=0.
- NCORES=4, req=4'b1010 with rr=2 -> gnt=4'b1000 (core3), rr becomes 0; next grant goes to core1.
